// File: rtl/fuzzy_inference_engine.sv
// Two-input fuzzy controller: triangular fuzzification, min/max rule inference,
// singleton weighted-average defuzzification via a serial restoring divider.
module fuzzy_inference_engine #(
    parameter logic [11:0] OUT_LO  = 12'd0,
    parameter logic [11:0] OUT_MID = 12'd2048,
    parameter logic [11:0] OUT_HI  = 12'd4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] v1,
    input  logic [11:0] v2,
    output logic        busy,
    output logic        done,
    output logic [11:0] out
);

    typedef enum logic [2:0] {IDLE, FUZZ, RULE, MAC, DIV} state_t;

    state_t      state_q;
    logic [11:0] v1_q, v2_q;
    logic [23:0] mu1_q, mu2_q;
    logic [7:0]  wLo_q, wMid_q, wHi_q;
    logic [9:0]  den_q, rem_q;
    logic [21:0] quo_q;
    logic [4:0]  cnt_q;
    logic        busy_q, done_q;
    logic [11:0] out_q;

    logic [7:0]  wLo_d, wMid_d, wHi_d;
    logic [21:0] num_d;
    logic [9:0]  den_d, rem_d;
    logic [21:0] quo_d;
    logic [10:0] remShift;
    logic        geq;

    // Returns {LOW, MID, HIGH} membership degrees; they always sum to 255.
    function automatic logic [23:0] fuzzify(input logic [11:0] x);
        logic [7:0] lo, mid, hi;
        lo  = x[11] ? 8'd0 : 8'((12'd2047 - x) >> 3);
        mid = x[11] ? 8'((12'd4095 - x) >> 3) : 8'(x >> 3);
        hi  = x[11] ? 8'((x - 12'd2048) >> 3) : 8'd0;
        return {lo, mid, hi};
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    always_comb begin
        wLo_d  = max3(min8(mu1_q[23:16], mu2_q[23:16]),
                      min8(mu1_q[23:16], mu2_q[15:8]),
                      min8(mu1_q[15:8],  mu2_q[23:16]));
        wMid_d = max3(min8(mu1_q[23:16], mu2_q[7:0]),
                      min8(mu1_q[15:8],  mu2_q[15:8]),
                      min8(mu1_q[7:0],   mu2_q[23:16]));
        wHi_d  = max3(min8(mu1_q[15:8],  mu2_q[7:0]),
                      min8(mu1_q[7:0],   mu2_q[15:8]),
                      min8(mu1_q[7:0],   mu2_q[7:0]));
        num_d  = 22'(wLo_q) * 22'(OUT_LO) + 22'(wMid_q) * 22'(OUT_MID)
               + 22'(wHi_q) * 22'(OUT_HI);
        den_d  = 10'(wLo_q) + 10'(wMid_q) + 10'(wHi_q);
    end

    // One restoring-division step: the dividend shifts out of quo_q as quotient bits shift in.
    always_comb begin
        remShift = {rem_q, quo_q[21]};
        geq      = remShift >= {1'b0, den_q};
        rem_d    = geq ? 10'(remShift - {1'b0, den_q}) : remShift[9:0];
        quo_d    = {quo_q[20:0], geq};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            v1_q    <= '0;
            v2_q    <= '0;
            mu1_q   <= '0;
            mu2_q   <= '0;
            wLo_q   <= '0;
            wMid_q  <= '0;
            wHi_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        v1_q    <= v1;
                        v2_q    <= v2;
                        busy_q  <= 1'b1;
                        state_q <= FUZZ;
                    end
                end
                FUZZ: begin
                    mu1_q   <= fuzzify(v1_q);
                    mu2_q   <= fuzzify(v2_q);
                    state_q <= RULE;
                end
                RULE: begin
                    wLo_q   <= wLo_d;
                    wMid_q  <= wMid_d;
                    wHi_q   <= wHi_d;
                    state_q <= MAC;
                end
                MAC: begin
                    quo_q   <= num_d;
                    den_q   <= den_d;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= DIV;
                end
                DIV: begin
                    // 22 step edges, then one edge to publish so done lands in a fixed cycle.
                    if (cnt_q == 5'd22) begin
                        out_q   <= (den_q == '0) ? OUT_MID : quo_q[11:0];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: doc/fuzzy_inference_engine.md
FUZZY_INFERENCE_ENGINE -- requirements
Module: fuzzy_inference_engine

Interface
REQ-001 Parameter OUT_LO, default 0: crisp singleton (12-bit) for output class LOW.
REQ-002 Parameter OUT_MID, default 2048: crisp singleton for output class MID.
REQ-003 Parameter OUT_HI, default 4095: crisp singleton for output class HIGH.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request; v1/v2 valid in same cycle.
REQ-007 v1  input  12  unsigned sample, channel 1 (ADC controller output).
REQ-008 v2  input  12  unsigned sample, channel 2.
REQ-009 busy  output  1  high while an inference is in progress.
REQ-010 done  output  1  one-cycle pulse; out valid and updated.
REQ-011 out  output  12  crisp result; holds until next done.

Function
REQ-012 Cycle k = interval after rising edge k; start sampled high at edge 0 in IDLE captures v1, v2.
REQ-013 FSM states: IDLE -> FUZZ -> RULE -> MAC -> DIV -> IDLE; each state advances on the next edge except DIV (22 edges).
REQ-014 FUZZ: per input x, 8-bit degrees: L = x<2048 ? (2047-x)>>3 : 0; M = x<2048 ? x>>3 : (4095-x)>>3; H = x>=2048 ? (x-2048)>>3 : 0 (L+M+H = 255 always).
REQ-015 RULE: strength = min(mu1, mu2) for all 9 pairs; consequents: LL,LM,ML -> LOW; LH,MM,HL -> MID; MH,HM,HH -> HIGH.
REQ-016 RULE: class weights W_LO, W_MID, W_HI (8-bit) = max of strengths mapped to that class.
REQ-017 MAC: numerator (22-bit) = W_LO*OUT_LO + W_MID*OUT_MID + W_HI*OUT_HI; denominator (10-bit) = W_LO+W_MID+W_HI; no overflow permitted at these widths.
REQ-018 DIV: sequential restoring division, one quotient bit per cycle, 22 cycles, quotient truncated (floor); low 12 bits driven to out.
REQ-019 Denominator zero: out = OUT_MID, still at the fixed latency.
REQ-020 Latency fixed: out updated and done=1 in cycle 26 only; busy=1 in cycles 0..25, busy=0 in cycle 26.
REQ-021 start while busy=1 ignored; no queuing, captured operands unaffected.
REQ-022 start high in cycle 26 (done high) sampled at edge 27 in IDLE and accepted; back-to-back period 27 cycles.
REQ-023 v1/v2 changes after edge 0 do not affect the current result.

Reset
REQ-024 rst high: FSM -> IDLE immediately, busy=0, done=0, out=0, all datapath registers cleared.
REQ-025 rst mid-operation aborts the inference; no done pulse issued for it; out stays 0.
REQ-026 First start after rst release accepted normally with full 26-cycle latency.

Verification
REQ-027 v1=0, v2=0, start -> done in cycle 26, out=0.
REQ-028 v1=2048, v2=2048 -> out=2048; v1=4095, v2=4095 -> out=4095.
REQ-029 v1=1024, v2=2048 -> W_LO=127, W_MID=128, W_HI=0 -> out=1028 (262144/255 floor).
REQ-030 start pulsed again at cycles 5 and 20 with different v1/v2 -> ignored; single done, result from first operands.
REQ-031 rst asserted in cycle 15 (DIV) -> busy/done/out=0 at once; no done; next start after release yields correct result at cycle 26.
REQ-032 start held high continuously, v1=v2=4095 -> done pulses at cycles 26, 53, 80, each out=4095.
